// File: rtl/float_pkg.sv
// Shared float32 definitions for the tree adder and its control stage.
// Provides the word and vector types, the sequencer state encoding, and a
// few single-precision constants that are handy for bring-up batches.
package float_pkg;

    localparam int FLOAT_W = 32;
    localparam int TREE_N  = 4;

    typedef logic [FLOAT_W-1:0] float_t;
    typedef float_t [TREE_N-1:0] float_vec_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    localparam float_t F_1P2 = 32'h3F99999A;
    localparam float_t F_1P4 = 32'h3FB33333;
    localparam float_t F_1P8 = 32'h3FE66666;
    localparam float_t F_1P9 = 32'h3FF33333;

endpackage

// File: rtl/tree_add_sequencer.sv
// Control stage around the N-input float32 tree adder.
// Packs N serially accepted words into a held operand vector, pulses the
// adder's start, waits its fixed latency, captures the sum and presents it
// on a valid/ready output. One batch in flight at a time; no arithmetic here.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data/in_valid    operand stream from the producer
//   in_ready            high only in FILL (and never while rst is high)
//   tree_array          operand vector, element 0 = first accepted word
//   tree_start          one-cycle launch pulse, high only in LAUNCH
//   tree_result         sum returned by the tree adder
//   out_data/out_valid  captured sum, held until out_ready
//   out_ready           consumer handshake, ignored outside HOLD
//   busy                high in every state other than FILL
module tree_add_sequencer
    import float_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = FLOAT_W,
    parameter int LATENCY = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N-1:0][W-1:0] tree_array,
    output logic                tree_start,
    input  logic [W-1:0]        tree_result,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    seq_state_t       state, state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_slot;
    logic             capture;

    assign in_ready  = (state == FILL) && !rst;
    assign busy      = (state != FILL);
    assign accept    = in_valid && in_ready;
    assign last_slot = (idx == IDX_W'(N - 1));
    // cnt is 1 in the first WAIT cycle, so it equals the cycle offset from
    // the tree_start cycle; the adder's result is valid when it hits LATENCY.
    assign capture   = (state == WAIT) && (cnt == CNT_W'(LATENCY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && last_slot) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (capture) state_next = HOLD;
            HOLD:    if (out_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            cnt        <= '0;
            tree_array <= '0;
            tree_start <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            // Registered so the pulse coincides exactly with the LAUNCH state.
            tree_start <= (state_next == LAUNCH);

            if (accept) begin
                tree_array[idx] <= in_data;
                idx             <= last_slot ? '0 : idx + 1'b1;
            end

            if (state == LAUNCH) begin
                cnt <= CNT_W'(1);
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end

            if (capture) begin
                out_data  <= tree_result;
                out_valid <= 1'b1;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tree_add_sequencer.sv
module tb_tree_add_sequencer;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 10;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    vec_t         tree_array;
    logic         tree_start;
    logic [W-1:0] tree_result;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    tree_add_sequencer #(.N(N), .W(W), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tree_array  (tree_array),
        .tree_start  (tree_start),
        .tree_result (tree_result),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Adder stand-in: a checksum of the operands, visible only on the exact
    // cycle LATENCY after tree_start and zero on every other cycle.
    function automatic logic [W-1:0] model_sum(input vec_t v);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + v[i];
        return s ^ 32'hDEADBEEF;
    endfunction

    int           stub_cnt = 0;
    logic         stub_active = 1'b0;
    logic [W-1:0] stub_val = '0;

    always @(posedge clk) begin
        if (tree_start) begin
            stub_active <= 1'b1;
            stub_cnt    <= 1;
            stub_val    <= model_sum(tree_array);
        end else if (stub_active) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt >= LAT) stub_active <= 1'b0;
        end
    end

    assign tree_result = (stub_active && stub_cnt == LAT) ? stub_val : '0;

    // Consumer readiness: 0 = always ready, 1 = random, 2 = stalled.
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard state
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic         rst_prev = 1'b0;
    logic         hs_prev = 1'b0;
    logic [W-1:0] acc[$];
    vec_t         arr_q[$];
    logic [W-1:0] exp_q[$];
    logic         launch_pending = 1'b0;
    int           exp_start_cyc = 0;
    logic         waiting_out = 1'b0;
    int           exp_out_cyc = 0;
    logic         out_seen = 1'b0;
    logic [W-1:0] held = '0;
    logic         spacing_on = 1'b0;
    int           prev_rise = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        vec_t v;
        cyc++;
        if (rst) begin
            chk("in_ready_in_reset", 128'(in_ready), 128'(0));
            acc.delete();
            arr_q.delete();
            exp_q.delete();
            launch_pending = 1'b0;
            waiting_out    = 1'b0;
            out_seen       = 1'b0;
            hs_prev        = 1'b0;
        end else begin
            if (rst_prev) begin
                chk("rst_tree_start", 128'(tree_start), 128'(0));
                chk("rst_out_valid", 128'(out_valid), 128'(0));
                chk("rst_out_data", 128'(out_data), 128'(0));
                chk("rst_tree_array", 128'(tree_array), 128'(0));
                chk("rst_busy", 128'(busy), 128'(0));
            end

            chk("in_ready_vs_busy", 128'(in_ready), 128'(!busy));

            if (hs_prev) begin
                chk("fill_after_hold", 128'(busy), 128'(0));
                chk("out_valid_dropped", 128'(out_valid), 128'(0));
            end
            hs_prev = 1'b0;

            if (tree_start || (launch_pending && cyc >= exp_start_cyc)) begin
                chk("tree_start_expected", 128'(launch_pending), 128'(1));
                if (launch_pending) begin
                    chk("tree_start", 128'(tree_start), 128'(1));
                    chk("tree_start_cycle", 128'(cyc), 128'(exp_start_cyc));
                    chk("tree_array", 128'(tree_array), 128'(arr_q.pop_front()));
                    launch_pending = 1'b0;
                end
            end

            if (out_valid && out_seen) begin
                chk("out_data_stable", 128'(out_data), 128'(held));
                chk("in_ready_in_hold", 128'(in_ready), 128'(0));
            end else if (out_valid || (waiting_out && cyc >= exp_out_cyc)) begin
                chk("out_valid_expected", 128'(waiting_out), 128'(1));
                if (waiting_out) begin
                    chk("out_valid", 128'(out_valid), 128'(1));
                    chk("out_valid_cycle", 128'(cyc), 128'(exp_out_cyc));
                    chk("out_data", 128'(out_data), 128'(exp_q.pop_front()));
                    waiting_out = 1'b0;
                    out_seen    = out_valid;
                    held        = out_data;
                    if (spacing_on) begin
                        if (prev_rise >= 0) chk("batch_period", 128'(cyc - prev_rise), 128'(N + LAT + 2));
                        prev_rise = cyc;
                    end
                end
            end

            if (out_valid && out_seen && out_ready) begin
                out_seen = 1'b0;
                hs_prev  = 1'b1;
            end

            if (in_valid && in_ready) begin
                acc.push_back(in_data);
                if (acc.size() == N) begin
                    for (int i = 0; i < N; i++) v[i] = acc[i];
                    arr_q.push_back(v);
                    exp_q.push_back(model_sum(v));
                    launch_pending = 1'b1;
                    exp_start_cyc  = cyc + 1;
                    waiting_out    = 1'b1;
                    exp_out_cyc    = cyc + 2 + LAT;
                    acc.delete();
                end
            end
        end
        rst_prev = rst;
    end

    // Stimulus
    task automatic send_word(input logic [W-1:0] w, input int gap);
        logic done;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        done     = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) begin
            $display("FAIL in_ready_timeout: word %0h never accepted", w);
            $fatal(1, "stalled");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input vec_t v, input int maxgap);
        for (int i = 0; i < N; i++) send_word(v[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!waiting_out && !out_seen && !launch_pending) done = 1'b1;
        end
        if (!done) begin
            $display("FAIL idle_timeout: batch never completed");
            $fatal(1, "stalled");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Known operands back-to-back
        ready_mode = 0;
        v = {32'h3FF33333, 32'h3FE66666, 32'h3FB33333, 32'h3F99999A};
        send_batch(v, 0);
        wait_idle();

        // All-zero batch: stub value is exactly 0xDEADBEEF
        send_batch('0, 0);
        wait_idle();

        // Random words, random gaps, random consumer
        ready_mode = 1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) v[i] = $urandom();
            send_batch(v, 3);
        end
        wait_idle();

        // Stalled consumer for 20 cycles in HOLD
        ready_mode = 2;
        for (int i = 0; i < N; i++) v[i] = $urandom();
        send_batch(v, 0);
        for (int i = 0; i < 100 && !out_seen; i++) @(negedge clk);
        repeat (20) @(posedge clk);
        #1;
        ready_mode = 0;
        wait_idle();

        // Reset after half a batch, then a clean batch
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        pulse_reset();
        v = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        send_batch(v, 0);
        wait_idle();

        // Reset during WAIT, then a clean batch
        for (int i = 0; i < N; i++) v[i] = $urandom();
        send_batch(v, 0);
        repeat (4) @(posedge clk);
        #1;
        pulse_reset();
        v = {32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
        send_batch(v, 1);
        wait_idle();

        // Three consecutive batches at full rate
        spacing_on = 1'b1;
        send_batch({32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 0);
        send_batch({32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000}, 0);
        send_batch({32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000}, 0);
        wait_idle();
        spacing_on = 1'b0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
